// File: rtl/watchdog_pkg.sv
// Shared definitions for the multi-channel watchdog: per-channel state encoding.
package watchdog_pkg;

    localparam logic [1:0] WD_IDLE     = 2'd0;
    localparam logic [1:0] WD_COUNTING = 2'd1;
    localparam logic [1:0] WD_EXPIRED  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = WD_IDLE,
        ST_COUNTING = WD_COUNTING,
        ST_EXPIRED  = WD_EXPIRED
    } wd_state_e;

endpackage

// File: rtl/watchdog_channel.sv
// One watchdog channel: FSM, saturating idle counter, timeout register,
// latched pending flag. Optional prewarn flag under WATCHDOG_PREWARN_EN.
module watchdog_channel
    import watchdog_pkg::*;
#(
    parameter int COUNTER_SIZE    = 8,
    parameter int DEFAULT_TIMEOUT = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    keepalive,
    input  logic                    ack,
    input  logic                    cfg_we,
    input  logic [COUNTER_SIZE-1:0] cfg_timeout,
    output logic                    pending_o,
    output logic                    pending_next_o,
    output logic [1:0]              state_o
`ifdef WATCHDOG_PREWARN_EN
    ,
    output logic                    prewarn_o
`endif
);

    wd_state_e               state_q, state_d;
    logic [COUNTER_SIZE-1:0] counter_q, counter_d;
    logic [COUNTER_SIZE-1:0] timeout_q, timeout_d;
    logic                    pending_q, pending_d;

    // Next-state logic; enable=0 overrides everything, keepalive beats expiry.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        pending_d = pending_q;
        timeout_d = cfg_we ? cfg_timeout : timeout_q;
        if (!enable) begin
            state_d   = ST_IDLE;
            counter_d = '0;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_COUNTING;
                    counter_d = '0;
                end
                ST_COUNTING: begin
                    if (keepalive) begin
                        counter_d = '0;
                    end else if ((timeout_q != '0) && (counter_q >= timeout_q)) begin
                        state_d   = ST_EXPIRED;
                        counter_d = '0;
                        pending_d = 1'b1;
                    end else if (counter_q != '1) begin
                        counter_d = counter_q + COUNTER_SIZE'(1);
                    end
                end
                ST_EXPIRED: begin
                    counter_d = '0;
                    if (ack) begin
                        state_d   = ST_COUNTING;
                        pending_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    counter_d = '0;
                    pending_d = 1'b0;
                end
            endcase
        end
    end

    // Channel state registers, cleared asynchronously (timeout back to default).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            timeout_q <= COUNTER_SIZE'(DEFAULT_TIMEOUT);
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            timeout_q <= timeout_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o      = pending_q;
    assign pending_next_o = pending_d;
    assign state_o        = state_q;

`ifdef WATCHDOG_PREWARN_EN
    logic prewarn_q, prewarn_d;

    // Prewarn from next-state values so it drops on the same edge as keepalive/expiry/disable.
    always_comb begin
        prewarn_d = (state_d == ST_COUNTING) && (timeout_d != '0) &&
                    (counter_d >= (timeout_d >> 1));
    end

    // Prewarn register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) prewarn_q <= 1'b0;
        else       prewarn_q <= prewarn_d;
    end

    assign prewarn_o = prewarn_q;
`endif

endmodule

// File: rtl/watchdog_multi.sv
// Multi-channel watchdog top: config decode, merged interrupt line and
// lowest-index pending encoder. Optional prewarn outputs: WATCHDOG_PREWARN_EN.
// dbg_state exposes each channel's FSM state (2 bits per channel, ch0 at LSBs).
module watchdog_multi
    import watchdog_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int COUNTER_SIZE    = 8,
    parameter int DEFAULT_TIMEOUT = 16,
    parameter int CH_IDX_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CHANNELS-1:0]   enable,
    input  logic [NUM_CHANNELS-1:0]   keepalive,
    input  logic                      cfg_we,
    input  logic [CH_IDX_W-1:0]       cfg_channel,
    input  logic [COUNTER_SIZE-1:0]   cfg_timeout,
    input  logic [NUM_CHANNELS-1:0]   ack,
    output logic [NUM_CHANNELS-1:0]   irq_pending,
    output logic                      interruption,
    output logic [CH_IDX_W-1:0]       irq_channel,
`ifdef WATCHDOG_PREWARN_EN
    output logic [NUM_CHANNELS-1:0]   prewarn,
`endif
    output logic [2*NUM_CHANNELS-1:0] dbg_state
);

    logic [NUM_CHANNELS-1:0] ch_we;
    logic [NUM_CHANNELS-1:0] pending_next;
    logic [1:0]              ch_state [NUM_CHANNELS];

    logic                interruption_q, interruption_d;
    logic [CH_IDX_W-1:0] irq_channel_q, irq_channel_d;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        // Out-of-range channel indices simply match no channel.
        assign ch_we[i] = cfg_we && (cfg_channel == CH_IDX_W'(i));

        watchdog_channel #(
            .COUNTER_SIZE    (COUNTER_SIZE),
            .DEFAULT_TIMEOUT (DEFAULT_TIMEOUT)
        ) u_ch (
            .clock          (clock),
            .reset          (reset),
            .enable         (enable[i]),
            .keepalive      (keepalive[i]),
            .ack            (ack[i]),
            .cfg_we         (ch_we[i]),
            .cfg_timeout    (cfg_timeout),
            .pending_o      (irq_pending[i]),
            .pending_next_o (pending_next[i]),
            .state_o        (ch_state[i])
`ifdef WATCHDOG_PREWARN_EN
            ,
            .prewarn_o      (prewarn[i])
`endif
        );
    end

    // Merge and priority-encode next-state pending so outputs align with irq_pending.
    always_comb begin
        interruption_d = |pending_next;
        irq_channel_d  = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (pending_next[i]) irq_channel_d = CH_IDX_W'(i);
        end
    end

    // Merged interrupt registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            interruption_q <= 1'b0;
            irq_channel_q  <= '0;
        end else begin
            interruption_q <= interruption_d;
            irq_channel_q  <= irq_channel_d;
        end
    end

    // Pack per-channel FSM states into the debug vector.
    always_comb begin
        dbg_state = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            dbg_state[2*i +: 2] = ch_state[i];
        end
    end

    assign interruption = interruption_q;
    assign irq_channel  = irq_channel_q;

endmodule

// File: tb/tb_watchdog_multi.sv
// Directed bench for watchdog_multi (4 channels, 8-bit counters, default timeout 16).
module tb_watchdog_multi;

    logic       clock;
    logic       reset;
    logic [3:0] enable;
    logic [3:0] keepalive;
    logic       cfg_we;
    logic [1:0] cfg_channel;
    logic [7:0] cfg_timeout;
    logic [3:0] ack;
    logic [3:0] irq_pending;
    logic       interruption;
    logic [1:0] irq_channel;
    logic [7:0] dbg_state;
`ifdef WATCHDOG_PREWARN_EN
    logic [3:0] prewarn;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic seen_pending;

    watchdog_multi #(
        .NUM_CHANNELS    (4),
        .COUNTER_SIZE    (8),
        .DEFAULT_TIMEOUT (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .keepalive    (keepalive),
        .cfg_we       (cfg_we),
        .cfg_channel  (cfg_channel),
        .cfg_timeout  (cfg_timeout),
        .ack          (ack),
        .irq_pending  (irq_pending),
        .interruption (interruption),
        .irq_channel  (irq_channel),
`ifdef WATCHDOG_PREWARN_EN
        .prewarn      (prewarn),
`endif
        .dbg_state    (dbg_state)
    );

    // Clock: 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] t);
        cfg_we      = 1'b1;
        cfg_channel = ch;
        cfg_timeout = t;
        tick();
        cfg_we      = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = '0;
        keepalive   = '0;
        cfg_we      = 1'b0;
        cfg_channel = '0;
        cfg_timeout = '0;
        ack         = '0;
        #12;
        chk("reset_pending", 32'(irq_pending), 32'h0);
        chk("reset_irq", 32'(interruption), 32'h0);
        chk("reset_channel", 32'(irq_channel), 32'h0);
        chk("reset_state", 32'(dbg_state), 32'h00);
        @(posedge clock);
        #1 reset = 1'b0;

        // ch0, default timeout 16: pending exactly 17 edges after the enable edge.
        enable[0] = 1'b1;
        tick();
        chk("ch0_counting", 32'(dbg_state), 32'h01);
        ticks(16);
        chk("ch0_t16_before", 32'(irq_pending), 32'h0);
        tick();
        chk("ch0_t16_pending", 32'(irq_pending), 32'h1);
        chk("ch0_t16_irq", 32'(interruption), 32'h1);
        chk("ch0_t16_chan", 32'(irq_channel), 32'h0);
        chk("ch0_expired_state", 32'(dbg_state), 32'h02);
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        chk("ch0_ack_pending", 32'(irq_pending), 32'h0);
        chk("ch0_ack_irq", 32'(interruption), 32'h0);
        enable[0] = 1'b0;
        tick();
        chk("ch0_disabled", 32'(dbg_state), 32'h00);

        // ch1 T=4 with keepalive every third cycle: never expires.
        cfg_write(2'd1, 8'd4);
        enable[1] = 1'b1;
        tick();
        seen_pending = 1'b0;
        for (int i = 0; i < 100; i++) begin
            keepalive[1] = (i % 3 == 2);
            tick();
            if (irq_pending != 4'h0) seen_pending = 1'b1;
        end
        chk("ch1_keepalive_no_expiry", 32'(seen_pending), 32'h0);
        keepalive[1] = 1'b1;
        tick();
        keepalive[1] = 1'b0;
        ticks(4);
        chk("ch1_t4_before", 32'(irq_pending), 32'h0);
        tick();
        chk("ch1_t4_pending", 32'(irq_pending), 32'h2);
        chk("ch1_t4_chan", 32'(irq_channel), 32'h1);
        // Disable wins over a simultaneous ack.
        enable[1] = 1'b0;
        ack[1]    = 1'b1;
        tick();
        ack[1]    = 1'b0;
        chk("ch1_disable_pending", 32'(irq_pending), 32'h0);
        chk("ch1_disable_irq", 32'(interruption), 32'h0);
        chk("ch1_disable_state", 32'(dbg_state), 32'h00);

        // ch2 and ch3 expire on the same edge.
        cfg_write(2'd2, 8'd3);
        cfg_write(2'd3, 8'd3);
        enable[3:2] = 2'b11;
        tick();
        ticks(3);
        chk("ch23_before", 32'(irq_pending), 32'h0);
        tick();
        chk("ch23_pending", 32'(irq_pending), 32'hC);
        chk("ch23_chan", 32'(irq_channel), 32'h2);
        ack[2] = 1'b1;
        tick();
        ack[2] = 1'b0;
        chk("ack2_pending", 32'(irq_pending), 32'h8);
        chk("ack2_chan", 32'(irq_channel), 32'h3);
        chk("ack2_irq", 32'(interruption), 32'h1);
        ack[3] = 1'b1;
        tick();
        ack[3] = 1'b0;
        chk("ack3_pending", 32'(irq_pending), 32'h0);
        chk("ack3_irq", 32'(interruption), 32'h0);
        chk("ack3_chan", 32'(irq_channel), 32'h0);
        enable[3:2] = 2'b00;
        tick();

        // ch0 at count 10, timeout lowered to 5: expiry on the next edge, ack there ignored.
        enable[0] = 1'b1;
        tick();
        ticks(10);
        cfg_write(2'd0, 8'd5);
        chk("ch0_lower_before", 32'(irq_pending), 32'h0);
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        chk("ch0_lower_expire", 32'(irq_pending), 32'h1);
        tick();
        chk("ch0_ack_ignored", 32'(irq_pending), 32'h1);
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        chk("ch0_late_ack", 32'(irq_pending), 32'h0);

        // Timeout 0: counter saturates, no expiry.
        cfg_write(2'd0, 8'd0);
        seen_pending = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (irq_pending != 4'h0) seen_pending = 1'b1;
        end
        chk("ch0_t0_no_expiry", 32'(seen_pending), 32'h0);
        chk("ch0_t0_counting", 32'(dbg_state), 32'h01);

`ifdef WATCHDOG_PREWARN_EN
        // Prewarn on ch1 with T=8: rises at count 4, drops on keepalive; never with T=0.
        cfg_write(2'd1, 8'd8);
        enable[1] = 1'b1;
        tick();
        ticks(3);
        chk("pw_before", 32'(prewarn), 32'h0);
        tick();
        chk("pw_rise", 32'(prewarn), 32'h2);
        keepalive[1] = 1'b1;
        tick();
        keepalive[1] = 1'b0;
        chk("pw_keepalive_drop", 32'(prewarn), 32'h0);
        cfg_write(2'd1, 8'd0);
        seen_pending = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (prewarn != 4'h0 || irq_pending != 4'h0) seen_pending = 1'b1;
        end
        chk("pw_t0_quiet", 32'(seen_pending), 32'h0);
        enable[1] = 1'b0;
        tick();
`endif

        // ch3 T=1 expires, then async reset mid-count clears everything at once.
        cfg_write(2'd3, 8'd1);
        enable[3] = 1'b1;
        tick();
        tick();
        chk("ch3_t1_before", 32'(irq_pending), 32'h0);
        tick();
        chk("ch3_t1_pending", 32'(irq_pending), 32'h8);
        #2 reset = 1'b1;
        #1;
        chk("async_pending", 32'(irq_pending), 32'h0);
        chk("async_irq", 32'(interruption), 32'h0);
        chk("async_chan", 32'(irq_channel), 32'h0);
        chk("async_state", 32'(dbg_state), 32'h00);
        enable = '0;
        @(posedge clock);
        #1 reset = 1'b0;

        // Timeout register back to 16 after reset.
        enable[0] = 1'b1;
        tick();
        ticks(16);
        chk("post_reset_before", 32'(irq_pending), 32'h0);
        tick();
        chk("post_reset_pending", 32'(irq_pending), 32'h1);
        chk("post_reset_irq", 32'(interruption), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
